// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg -- shared definitions for the multi-cycle divider.
//   div_state_t : divider FSM states (FREE, BYZERO, ON, END)
//   DIV_STEPS   : number of restoring radix-2 iterations per divide
//   DIV_START / DIV_STOP, DIV_RESULT_READY / DIV_RESULT_NOT_READY :
//                 handshake encodings seen by the EX stage
// -----------------------------------------------------------------------------
package div_unit_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BYZERO = 2'b01,
      ON     = 2'b10,
      END    = 2'b11
   } div_state_t;

   localparam int DIV_STEPS = 32;

   // Handshake encodings shared with the EX stage
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- 32-bit signed/unsigned restoring divider, one bit per cycle.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high until ready_o is seen
//   annul_i       cancels any divide in flight (priority over start_i)
//   result_o      {remainder, quotient}, registered
//   ready_o       registered, 1 = result_o valid
//
// Configuration macro: DIV_FAST_ZERO_EN -- when defined, a zero dividend
// (nonzero divisor) skips the iteration and completes through BYZERO.
// -----------------------------------------------------------------------------
module div_unit
   import div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   div_state_t  r_state;
   logic [5:0]  r_cnt;
   logic [64:0] r_work;     // [64:33] partial remainder, [32:1]/[31:0] quotient
   logic [31:0] r_divisor;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [63:0] r_result;
   logic        r_ready;

   logic [31:0] w_mag1;
   logic [31:0] w_mag2;
   logic [32:0] w_diff;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic        w_zero_path;

   // Operand magnitudes: negative operands are two's-complemented in signed mode
   assign w_mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign w_mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   // The working register is kept pre-shifted by one bit, so bits [63:32]
   // already hold the shifted partial remainder to test against the divisor.
   assign w_diff = {1'b0, r_work[63:32]} - {1'b0, r_divisor};

   // Sign fix-up applied once the iteration is complete
   assign w_quot = r_neg_q ? (~r_work[31:0] + 32'd1)  : r_work[31:0];
   assign w_rem  = r_neg_r ? (~r_work[64:33] + 32'd1) : r_work[64:33];

`ifdef DIV_FAST_ZERO_EN
   assign w_zero_path = (opdata2_i == 32'd0) || (opdata1_i == 32'd0);
`else
   assign w_zero_path = (opdata2_i == 32'd0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= FREE;
         r_cnt     <= 6'd0;
         r_work    <= 65'd0;
         r_divisor <= 32'd0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_result  <= 64'd0;
         r_ready   <= DIV_RESULT_NOT_READY;
      end else if (annul_i) begin
         r_state  <= FREE;
         r_cnt    <= 6'd0;
         r_work   <= 65'd0;
         r_result <= 64'd0;
         r_ready  <= DIV_RESULT_NOT_READY;
      end else begin
         case (r_state)
            FREE: begin
               r_result <= 64'd0;
               r_ready  <= DIV_RESULT_NOT_READY;
               if (start_i == DIV_START) begin
                  if (w_zero_path) begin
                     r_state <= BYZERO;
                  end else begin
                     r_state   <= ON;
                     r_cnt     <= 6'd0;
                     r_work    <= {32'd0, w_mag1, 1'b0};
                     r_divisor <= w_mag2;
                     r_neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                     r_neg_r   <= signed_div_i & opdata1_i[31];
                  end
               end
            end
            BYZERO: begin
               r_state  <= END;
               r_result <= 64'd0;
               r_ready  <= DIV_RESULT_READY;
            end
            ON: begin
               if (r_cnt == 6'(DIV_STEPS)) begin
                  r_state  <= END;
                  r_result <= {w_rem, w_quot};
                  r_ready  <= DIV_RESULT_READY;
               end else begin
                  // Negative difference: restore (plain shift, quotient bit 0)
                  if (w_diff[32])
                     r_work <= {r_work[63:0], 1'b0};
                  else
                     r_work <= {w_diff[31:0], r_work[31:0], 1'b1};
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            END: begin
               if (start_i == DIV_STOP) begin
                  r_state  <= FREE;
                  r_result <= 64'd0;
                  r_ready  <= DIV_RESULT_NOT_READY;
               end
            end
            default: r_state <= FREE;
         endcase
      end
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- scoreboard bench for div_unit. Stimulus pushes the expected
// result and completion cycle; a monitor pops on each rising ready_o.
// Honours DIV_FAST_ZERO_EN for the zero-dividend latency.
// -----------------------------------------------------------------------------
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = 32'd0;
   logic [31:0] opdata2_i = 32'd0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

`ifdef DIV_FAST_ZERO_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif

   typedef struct {
      logic [63:0] res;
      int          exp_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic prev_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Monitor: compare result and completion cycle on every rising ready_o
   always @(negedge clk) begin
      exp_t e;
      if (ready_o && !prev_rdy) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready actual=1 expected=0 result=%h", result_o);
         end else begin
            e = sb.pop_front();
            chk("sb_result", result_o, e.res);
            chk("sb_latency", 64'(cyc), 64'(e.exp_cyc));
         end
      end
      prev_rdy = ready_o;
   end

   // Issue a divide at a negedge, scramble operands after E0, wait for
   // ready, hold start one more cycle, then release and check the return to FREE.
   task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
      exp_t e;
      int   n;
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      e.res        = exp;
      e.exp_cyc    = cyc + 1 + lat;
      sb.push_back(e);
      @(negedge clk);
      opdata1_i    = 32'hDEADBEEF;
      opdata2_i    = 32'h00000000;
      signed_div_i = ~sg;
      n = 0;
      while (!ready_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout actual=0 expected=1 a=%h b=%h", a, b);
         start_i = 1'b0;
         @(negedge clk);
      end else begin
         @(negedge clk);
         chk("end_hold_ready", 64'(ready_o), 64'd1);
         chk("end_hold_result", result_o, exp);
         start_i = 1'b0;
         @(negedge clk);
         chk("free_ready", 64'(ready_o), 64'd0);
         chk("free_result", result_o, 64'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk("reset_ready", 64'(ready_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
      run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);
      run_div(1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 33);
      run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
      run_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 33);
      run_div(1'b0, 32'd5, 32'h10, 64'h00000005_00000000, 33);
      run_div(1'b0, 32'd5, 32'd0, 64'h0, 1);
      run_div(1'b1, 32'hFFFFFFF9, 32'd0, 64'h0, 1);
      run_div(1'b0, 32'd0, 32'd9, 64'h0, ZLAT);

      // Annul 10 cycles into ON: no result may appear
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      chk("annul_ready", 64'(ready_o), 64'd0);
      chk("annul_result", result_o, 64'd0);
      for (int i = 0; i < 40; i++) @(negedge clk);
      chk("annul_no_ready", 64'(ready_o), 64'd0);
      run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

      // Annul wins over start while in FREE
      opdata1_i = 32'd5;
      opdata2_i = 32'd0;
      start_i   = 1'b1;
      annul_i   = 1'b1;
      for (int i = 0; i < 3; i++) @(negedge clk);
      chk("annul_prio_ready", 64'(ready_o), 64'd0);
      start_i = 1'b0;
      annul_i = 1'b0;
      @(negedge clk);

      // Reset 20 cycles into ON
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 20; i++) @(negedge clk);
      start_i = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_on_ready", 64'(ready_o), 64'd0);
      chk("rst_on_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 40; i++) @(negedge clk);
      chk("rst_on_no_ready", 64'(ready_o), 64'd0);

      // Reset while in END: outputs clear asynchronously
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      begin
         exp_t e;
         e.res     = 64'h00000002_0000000E;
         e.exp_cyc = cyc + 34;
         sb.push_back(e);
      end
      for (int i = 0; i < 36; i++) @(negedge clk);
      chk("pre_rst_end_ready", 64'(ready_o), 64'd1);
      start_i = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_end_ready", 64'(ready_o), 64'd0);
      chk("rst_end_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_div(1'b0, 32'd1, 32'd1, 64'h00000000_00000001, 33);

      for (int i = 0; i < 5; i++) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
